sdr_qsram_controller: RTL and testbench

Initiator-side controller for the SDR_QSRAM synchronous memory. It accepts single-word read/write requests over a valid/ready host port and drives the memory's Enable/Read/Write/Refresh/Address pins. It owns the bidirectional data bus, driving it for writes and releasing it for reads, and inserts periodic refresh cycles autonomously. It sits between a host datapath and one SDR_QSRAM instance.

---
 rtl/sdr_qsram_controller_if.sv | 30 +++
 rtl/sdr_qsram_controller.sv | 113 +++++++++++
 tb/tb_sdr_qsram_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_qsram_controller_if.sv
// rtl/sdr_qsram_controller_if.sv - host request/response and memory control signals of the SDR_QSRAM controller
interface sdr_qsram_controller_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_enable;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_refresh;

    modport master (
        output req_valid, req_write, req_address, req_data,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_address, mem_enable, mem_read, mem_write, mem_refresh
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        output req_ready, rsp_valid, rsp_data,
        output mem_address, mem_enable, mem_read, mem_write, mem_refresh
    );
endinterface

// File: rtl/sdr_qsram_controller.sv
// rtl/sdr_qsram_controller.sv - single-word initiator for SDR_QSRAM with autonomous refresh
module sdr_qsram_controller #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int REFRESH_PERIOD = 256,
    parameter int REFRESH_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sdr_qsram_controller_if.slave bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);
    localparam int CNT_MAX = (READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(REFRESH_PERIOD);
    localparam logic [CW-1:0] RL_LOAD    = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] RC_LOAD    = CW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(REFRESH_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE, WR_CMD, RD_CMD, RD_WAIT, TURN, REF_CMD, REF_BUSY
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         timer;
    logic                  refresh_pending;
    logic                  drive;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  transfer;
    logic                  cnt_done;
    logic                  capture;

    assign bus.req_ready = (state == IDLE) && !refresh_pending;
    assign transfer      = bus.req_valid && bus.req_ready;
    assign cnt_done      = (cnt == '0);
    assign capture       = (state == RD_WAIT) && cnt_done;

    // The bus is only ever driven during the write command cycle.
    assign mem_data = drive ? wdata : {DATA_WIDTH{1'bz}};

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (refresh_pending)
                    next_state = REF_CMD;
                else if (transfer)
                    next_state = bus.req_write ? WR_CMD : RD_CMD;
            end
            WR_CMD:   next_state = IDLE;
            RD_CMD:   next_state = RD_WAIT;
            RD_WAIT:  if (cnt_done) next_state = TURN;
            TURN:     next_state = IDLE;
            REF_CMD:  next_state = REF_BUSY;
            REF_BUSY: if (cnt_done) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            timer           <= TIMER_LOAD;
            refresh_pending <= 1'b0;
            drive           <= 1'b0;
            wdata           <= '0;
            bus.mem_address <= '0;
            bus.mem_enable  <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_refresh <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
        end else begin
            state <= next_state;

            timer <= (timer == '0) ? TIMER_LOAD : timer - 1'b1;
            // Clearing wins, so an expiry that lands while pending is dropped.
            if ((state == IDLE) && refresh_pending)
                refresh_pending <= 1'b0;
            else if (timer == '0)
                refresh_pending <= 1'b1;

            if (state == RD_CMD)
                cnt <= RL_LOAD;
            else if (state == REF_CMD)
                cnt <= RC_LOAD;
            else if (!cnt_done)
                cnt <= cnt - 1'b1;

            if (transfer) begin
                bus.mem_address <= bus.req_address;
                wdata           <= bus.req_data;
            end

            // Command pins are registered from the next state so they appear with it.
            bus.mem_enable  <= (next_state == WR_CMD) || (next_state == RD_CMD) ||
                               (next_state == REF_CMD);
            bus.mem_read    <= (next_state == RD_CMD);
            bus.mem_write   <= (next_state == WR_CMD);
            bus.mem_refresh <= (next_state == REF_CMD);
            drive           <= (next_state == WR_CMD);

            bus.rsp_valid <= capture;
            if (capture)
                bus.rsp_data <= mem_data;
        end
    end
endmodule

// File: tb/tb_sdr_qsram_controller.sv
// tb/tb_sdr_qsram_controller.sv - scoreboard bench for sdr_qsram_controller with a behavioural SDR_QSRAM
module tb_sdr_qsram_controller;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RL = 1;
    localparam int RP = 16;
    localparam int RC = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sdr_qsram_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    wire [DW-1:0] mem_data;

    sdr_qsram_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
        .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .mem_data(mem_data)
    );

    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] shadow [256];
    logic          model_en = 1'b0;
    logic [DW-1:0] model_q  = '0;

    // SDR_QSRAM model: samples commands on the edge, returns read data one cycle later.
    assign mem_data = model_en ? model_q : {DW{1'bz}};
    always @(posedge clock) begin
        if (bus.mem_enable && bus.mem_write)
            model_mem[bus.mem_address] <= mem_data;
        model_en <= bus.mem_enable && bus.mem_read;
        model_q  <= model_mem[bus.mem_address];
    end

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;
    rsp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int n_wr_issued = 0, n_rd_issued = 0, n_wr_seen = 0, n_rd_seen = 0;
    int n_ref = 0, last_ref = -1, rsp_count = 0, last_rsp_cyc = -1;
    int overlap = 0, drive_err = 0, excl_err = 0;
    logic rsp_prev = 1'b0, ref_d1 = 1'b0, ref_d2 = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    always @(negedge clock) begin
        if (dut.drive && model_en) overlap++;
        if (dut.drive !== bus.mem_write) drive_err++;
        if (32'(bus.mem_read) + 32'(bus.mem_write) + 32'(bus.mem_refresh) > 1) excl_err++;
        if (!reset_n) begin
            rsp_prev = 1'b0; ref_d1 = 1'b0; ref_d2 = 1'b0; last_ref = -1;
        end else begin
            if (bus.mem_write) n_wr_seen++;
            if (bus.mem_read)  n_rd_seen++;
            if (bus.rsp_valid) begin
                rsp_t e;
                check_eq("rsp_single_pulse", 32'(rsp_prev), 0);
                if (sb.size() == 0) begin
                    check_eq("rsp_spurious", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check_eq("rsp_latency", cyc - e.cyc, 1 + RL);
                    rsp_count++;
                    last_rsp_cyc = cyc;
                end
            end
            if (bus.mem_refresh) begin
                n_ref++;
                check_eq("ref_ready_low", 32'(bus.req_ready), 0);
                if (last_ref >= 0)
                    check_eq("ref_interval", 32'((cyc - last_ref >= RP - 3) && (cyc - last_ref <= RP + 3)), 1);
                last_ref = cyc;
            end
            if (ref_d1 || ref_d2)
                check_eq("ref_busy_ready_low", 32'(bus.req_ready), 0);
            ref_d2   = ref_d1;
            ref_d1   = bus.mem_refresh;
            rsp_prev = bus.rsp_valid;
        end
    end

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int guard = 0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_address = a; bus.req_data = d;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            check_eq("req_accept_timeout", guard, 0);
        end else begin
            if (wr) begin
                shadow[a] = d;
                n_wr_issued++;
            end else begin
                sb.push_back('{shadow[a], cyc + 1});
                n_rd_issued++;
            end
            @(posedge clock);
        end
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clock);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    initial begin
        logic [AW-1:0] addrs [40];
        int before_ref, before_rsp;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            shadow[i]    = '0;
        end
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_address = '0; bus.req_data = '0;

        // Reset held with random host activity.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.req_valid   = 1'($urandom_range(1));
            bus.req_write   = 1'($urandom_range(1));
            bus.req_address = AW'($urandom_range(255));
            bus.req_data    = DW'($urandom_range(255));
        end
        #1;
        check_eq("rst_mem_ctrl", {28'd0, bus.mem_enable, bus.mem_read, bus.mem_write, bus.mem_refresh}, 0);
        check_eq("rst_mem_address", 32'(bus.mem_address), 0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 0);
        check_eq("rst_bus_released", 32'(dut.drive), 0);
        bus.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1 check_eq("rst_ready_after_release", 32'(bus.req_ready), 1);

        // Directed write then read of the same word.
        do_req(1'b1, 8'h12, 8'hA5);
        @(negedge clock);
        check_eq("wr_cmd_pins", {29'd0, bus.mem_enable, bus.mem_write, bus.mem_read}, 32'b110);
        check_eq("wr_mem_address", 32'(bus.mem_address), 32'h12);
        check_eq("wr_mem_data", 32'(mem_data), 32'hA5);
        do_req(1'b0, 8'h12, 8'h00);
        drain();
        repeat (3) @(negedge clock);
        check_eq("rsp_data_held", 32'(bus.rsp_data), 32'hA5);

        // Continuous back-to-back writes across several refresh periods, then read-back.
        for (int i = 0; i < 40; i++) begin
            addrs[i] = AW'($urandom_range(63));
            do_req(1'b1, addrs[i], DW'($urandom_range(255)));
        end
        for (int i = 0; i < 40; i++) do_req(1'b0, addrs[i], 8'h00);
        drain();

        // Read timed so the refresh timer expires while the read is in RD_WAIT.
        for (int i = 0; i < 40 && (cyc % RP) != 13; i++) @(negedge clock);
        before_ref = n_ref;
        before_rsp = rsp_count;
        do_req(1'b0, 8'h12, 8'h00);
        repeat (10) @(negedge clock);
        #1;
        check_eq("ref_after_read_rsp", rsp_count, before_rsp + 1);
        check_eq("ref_after_read_count", n_ref, before_ref + 1);
        check_eq("ref_after_read_gap", last_ref - last_rsp_cyc, 2);

        // Reset asserted while the read sits in RD_WAIT.
        do_req(1'b1, 8'h33, 8'h5C);
        do_req(1'b0, 8'h33, 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        sb.delete();
        #1;
        check_eq("rd_rst_mem_ctrl", {28'd0, bus.mem_enable, bus.mem_read, bus.mem_write, bus.mem_refresh}, 0);
        check_eq("rd_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check_eq("rd_rst_rsp_data", 32'(bus.rsp_data), 0);
        check_eq("rd_rst_mem_address", 32'(bus.mem_address), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        do_req(1'b0, 8'h33, 8'h00);
        drain();

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(2)) @(negedge clock);
            do_req(1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom_range(255)));
        end
        drain();
        repeat (4) @(negedge clock);

        check_eq("bus_overlap_cycles", overlap, 0);
        check_eq("bus_drive_outside_wr", drive_err, 0);
        check_eq("cmd_exclusive", excl_err, 0);
        check_eq("writes_seen", n_wr_seen, n_wr_issued);
        check_eq("reads_seen", n_rd_seen, n_rd_issued);
        check_eq("refresh_happened", 32'(n_ref > 20), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
